// File: rtl/correlation_feeder_if.sv
// Serial sample handshake into the correlation feeder.
interface correlation_feeder_if;
    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/correlation_feeder.sv
// Loads 10 coefficients, then shifts samples into a 10-deep window for the
// 10-tap 4-bit correlator, with window-fresh and y-aligned strobes.
module correlation_feeder (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 coef_load,
    correlation_feeder_if.slave  s,
    output logic [3:0]           x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9,
    output logic [3:0]           h_0, h_1, h_2, h_3, h_4, h_5, h_6, h_7, h_8, h_9,
    output logic                 coef_ok,
    output logic                 win_valid,
    output logic                 y_valid
);
    typedef enum logic [1:0] {IDLE, LOAD_H, FILL, RUN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] x [10];
    logic [3:0] h [10];
    logic       xfer;

    // Ready never looks at s_valid, so upstream can wait on it freely.
    assign s.s_ready = (state != IDLE) && !coef_load;
    assign xfer      = s.s_valid && s.s_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            coef_ok   <= 1'b0;
            win_valid <= 1'b0;
            y_valid   <= 1'b0;
            for (int unsigned i = 0; i < 10; i++) begin
                x[i] <= '0;
                h[i] <= '0;
            end
        end else begin
            y_valid   <= win_valid;
            win_valid <= 1'b0;
            if (coef_load) begin
                state   <= LOAD_H;
                cnt     <= '0;
                coef_ok <= 1'b0;
                for (int unsigned i = 0; i < 10; i++) x[i] <= '0;
            end else if (xfer) begin
                case (state)
                    LOAD_H: begin
                        for (int unsigned i = 0; i < 10; i++)
                            if (cnt == 4'(i)) h[i] <= s.s_data;
                        if (cnt == 4'd9) begin
                            coef_ok <= 1'b1;
                            cnt     <= '0;
                            state   <= FILL;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    FILL: begin
                        for (int unsigned i = 9; i > 0; i--) x[i] <= x[i-1];
                        x[0] <= s.s_data;
                        if (cnt == 4'd9) begin
                            cnt       <= '0;
                            state     <= RUN;
                            win_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    RUN: begin
                        for (int unsigned i = 9; i > 0; i--) x[i] <= x[i-1];
                        x[0]      <= s.s_data;
                        win_valid <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign {x_9, x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0} =
           {x[9], x[8], x[7], x[6], x[5], x[4], x[3], x[2], x[1], x[0]};
    assign {h_9, h_8, h_7, h_6, h_5, h_4, h_3, h_2, h_1, h_0} =
           {h[9], h[8], h[7], h[6], h[5], h[4], h[3], h[2], h[1], h[0]};
endmodule

// File: doc/correlation_feeder.md
# correlation_feeder

Front-end loader that drives the parallel inputs of the 10-tap, 4-bit correlator. It accepts a single serial 4-bit sample stream over a valid/ready handshake. The first 10 samples after a `coef_load` request are loaded as the coefficient vector. All later samples are shifted into a 10-deep sliding window presented on `x_0..x_9`. It also produces strobes that mark when the window is fresh and when the correlator's registered `y` corresponds to that window.

## Interface
- No parameters. Sample width is fixed at 4 bits and window depth at 10 taps, matching the correlator.
- `clock`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `coef_load`  input  1  one-cycle request to (re)load coefficients; has priority over sample acceptance.
- `s_data`  input  4  unsigned sample or coefficient.
- `s_valid`  input  1  `s_data` is valid.
- `s_ready`  output  1  block can accept `s_data` this cycle (combinational).
- `x_0` .. `x_9`  output  4 each  sliding window; `x_0` holds the newest sample.
- `h_0` .. `h_9`  output  4 each  coefficients; `h_0` is loaded first.
- `coef_ok`  output  1  all 10 coefficients are loaded.
- `win_valid`  output  1  one-cycle pulse: the `x` outputs hold a new full window.
- `y_valid`  output  1  `win_valid` delayed one cycle, aligned with the correlator's registered `y`.

## Operation
- A transfer occurs when `s_valid && s_ready` at a rising edge.
- Register widths:
  - 4-bit tap counter `cnt`, range 0–9.
  - 2-bit state register.
- States:
  - **IDLE**
    - `s_ready`=0.
    - `coef_load` → LOAD_H.
  - **LOAD_H**
    - `s_ready`=1.
    - Each transfer writes `h_cnt` and increments `cnt`.
    - The transfer at `cnt`=9 sets `coef_ok`=1, clears `cnt`, and moves to FILL.
  - **FILL**
    - `s_ready`=1.
    - Each transfer shifts the window: `x_(k+1)` ← `x_k` for k=0..8, `x_0` ← `s_data`, and `x_9`'s old value is discarded. `cnt` increments.
    - The transfer at `cnt`=9 moves to RUN and pulses `win_valid` (10th sample).
  - **RUN**
    - `s_ready`=1.
    - Each transfer shifts the window as in FILL and pulses `win_valid`.
    - `cnt` is unused.
- `coef_load` in any state:
  - Next state is LOAD_H, with `cnt`=0 and `coef_ok`=0.
  - `x_0..x_9` are cleared to 0.
  - `h` registers keep their values until overwritten.
  - `s_ready` is forced to 0 in the same cycle (`s_ready` = state≠IDLE && !`coef_load`), so no sample is consumed.
- `coef_load` during LOAD_H restarts loading at `h_0`.
- There is no arithmetic in this block. The correlator computes the sum of products; the maximum is 10·15·15 = 2250, which fits in its 12-bit `y`.
- Reset values:
  - state IDLE, `cnt` 0.
  - all `x` and `h` = 0.
  - `coef_ok`=0, `win_valid`=0, `y_valid`=0.
  - `s_ready`=0.

## Timing
- `s_ready` depends combinationally on state and `coef_load` only, never on `s_valid`.
- Full throughput: one sample per cycle while `s_valid` is held high.
- When a sample is accepted at edge E:
  - the `x` registers update at E;
  - `win_valid` is high during the cycle after E (RUN, or the 10th FILL transfer);
  - the correlator registers `y` at E+1;
  - `y_valid` is high during the cycle after E+1.
- Back-to-back transfers produce a continuous high on both `win_valid` and `y_valid`.
- `s_valid` low: no shift and no pulse; `win_valid` drops the next cycle, and `y_valid` drops one cycle later.
- Reset mid-stream:
  - synchronous; all outputs hold reset values from the following cycle;
  - a pending `y_valid` is cancelled;
  - a transfer presented in the reset cycle is dropped.
- `coef_load` in RUN: `win_valid` and `y_valid` may still show one in-flight pulse from the prior edge. After that, no `win_valid` occurs until 10 coefficients plus 10 samples have been accepted.

## Test plan
- **Reset.** Reset, then hold `s_valid`=1 with `coef_load`=0 for 20 cycles → `s_ready`=0 throughout; all outputs 0; no pulses.
- **Load and first window.** `coef_load`, then stream coefficients 1..10 and samples 1..10 back-to-back →
  - `h_0`=1 … `h_9`=10;
  - `coef_ok` rises after the 10th coefficient;
  - one `win_valid` after the 10th sample, with `x_0`=10 … `x_9`=1;
  - `y_valid` one cycle later, when the correlator `y` = Σk·(11−k) = 220.
- **Steady run with gaps.** In RUN, alternate `s_valid` 1/0 with samples 15,15,… → `win_valid` pulses only on the cycles after transfers; `y_valid` trails by one cycle; after 10 transfers all `x`=15.
- **Reload priority.** In RUN, assert `coef_load` together with `s_valid`=1 →
  - sample not consumed (`s_ready`=0 that cycle);
  - `x` cleared;
  - `coef_ok`=0;
  - the next 10 transfers go to `h_0..h_9`.
- **Restart during load.** `coef_load` again after 4 coefficients → loading restarts at `h_0`; `coef_ok` rises only after 10 further transfers.
- **Reset mid-stream.** Assert reset on the cycle after a RUN transfer → `y_valid` stays 0; state IDLE; all `x` and `h` = 0.
